mem_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares one single-port memory between NUM_REQ requesters.
- The memory has a valid/ready handshake with a registered ready and registered rdata.
- Per operation: accepts one request, issues a one-cycle memory access, waits for memory ready, returns read data or write completion to the owning requester.
- Sits between the requester agents and the memory, on the same clk/rst.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_rr_arbiter_rr_pick.sv | 30 +++
 rtl/mem_rr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
// Imported by the arbiter top and its picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, as one-hot grant plus encoded index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between
// NUM_REQ requesters: accept, one-cycle issue, wait, respond.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_valid,
  output logic                          mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic                          mem_ready,
  input  logic [WIDTH-1:0]              mem_rdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   nxt;
  logic [CW-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]   win;
  logic            any;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  assign nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // mem_* hold the latched command; mem_valid marks the ISSUE cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_wr_rd <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      mem_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            owner     <= win;
            mem_wr_rd <= req_wr_rd[win];
            mem_addr  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata <= req_wdata[win*WIDTH +: WIDTH];
            mem_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            rsp_valid[owner] <= 1'b1;
            if (!mem_wr_rd) rsp_rdata <= mem_rdata;
            ptr   <= nxt;
            state <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= 1'b1;
            ptr   <= nxt;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
